// File: rtl/pipeline_stall_controller_pkg.sv
// Shared constants and types for the pipeline stall controller:
// FSM state encodings, default parameter values and the control bundle.
package pipeline_stall_controller_pkg;

  localparam logic [0:0] STATE_RUN      = 1'b0;
  localparam logic [0:0] STATE_MEM_WAIT = 1'b1;

  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int TO_W_DEF    = 8;

  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic bubble_id_exe;
    logic flush_if_id;
    logic freeze_back;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{default: 1'b0};

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// A clear wins over a coincident increment; the count never wraps.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // NOTE: every path assigns q_d first via the default, so no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: combinational priority mux for per-stage
// controls, memory-wait FSM with timeout watchdog, and performance counters.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             freeze_back,
  output logic             mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic mstall;
  logic flush_act;
  logic stall_act;
  ctrl_t ctrl;

  assign mstall    = mem_req & ~mem_ready;
  assign flush_act = ~mstall & branch_taken;
  assign stall_act = ~mstall & ~branch_taken & hazard;

  // While in reset, bubble and flush are raised so pipeline registers clear on the same edge.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst) begin
      ctrl.bubble_id_exe = 1'b1;
      ctrl.flush_if_id   = 1'b1;
    end else if (mstall) begin
      ctrl.freeze_pc    = 1'b1;
      ctrl.freeze_if_id = 1'b1;
      ctrl.freeze_back  = 1'b1;
    end else if (flush_act) begin
      ctrl.flush_if_id   = 1'b1;
      ctrl.bubble_id_exe = 1'b1;
    end else if (stall_act) begin
      ctrl.freeze_pc     = 1'b1;
      ctrl.freeze_if_id  = 1'b1;
      ctrl.bubble_id_exe = 1'b1;
    end
  end

  assign freeze_pc     = ctrl.freeze_pc;
  assign freeze_if_id  = ctrl.freeze_if_id;
  assign bubble_id_exe = ctrl.bubble_id_exe;
  assign flush_if_id   = ctrl.flush_if_id;
  assign freeze_back   = ctrl.freeze_back;

  logic [0:0]      state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0] wait_inc;
  logic            timeout_q, timeout_d;

  assign wait_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + TO_W'(1);

  // The wait counter is zero on entry to MEM_WAIT, so the Nth stalled wait
  // cycle produces wait_inc == N; the flag rises at the end of the TIMEOUT-th.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    case (state_q)
      STATE_RUN: begin
        if (mstall) begin
          state_d = STATE_MEM_WAIT;
        end
      end
      STATE_MEM_WAIT: begin
        if (!mstall) begin
          state_d = STATE_RUN;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc >= TO_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = STATE_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STATE_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_wait    = (state_q == STATE_MEM_WAIT);
  assign mem_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (stall_act),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (mstall),
    .q   (memwait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (flush_act),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed testbench for pipeline_stall_controller with small counter and
// timeout parameters so saturation and watchdog behaviour are reachable quickly.
module tb_pipeline_stall_controller;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;

  logic             clk;
  logic             rst;
  logic             hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             perf_clr;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             bubble_id_exe;
  logic             flush_if_id;
  logic             freeze_back;
  logic             mem_wait;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] memwait_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int errors = 0;
  int checks = 0;

  // Control bundle order: {freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back}
  localparam logic [4:0] C_IDLE   = 5'b00000;
  localparam logic [4:0] C_HAZARD = 5'b11100;
  localparam logic [4:0] C_FLUSH  = 5'b00110;
  localparam logic [4:0] C_MSTALL = 5'b11001;
  localparam logic [4:0] C_RESET  = 5'b00110;

  pipeline_stall_controller #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .perf_clr      (perf_clr),
    .freeze_pc     (freeze_pc),
    .freeze_if_id  (freeze_if_id),
    .bubble_id_exe (bubble_id_exe),
    .flush_if_id   (flush_if_id),
    .freeze_back   (freeze_back),
    .mem_wait      (mem_wait),
    .mem_timeout   (mem_timeout),
    .stall_cnt     (stall_cnt),
    .memwait_cnt   (memwait_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ctrl_vec();
    return {freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back};
  endfunction

  // Inputs change on the falling edge; comb outputs settle well before the rising edge.
  task automatic drive(input logic h, input logic b, input logic rq, input logic rd, input logic pc);
    hazard       = h;
    branch_taken = b;
    mem_req      = rq;
    mem_ready    = rd;
    perf_clr     = pc;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 1, 0, 0);
    checks++;
    if (ctrl_vec() !== C_RESET) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want %b", ctrl_vec(), C_RESET);
    end
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({mem_wait, mem_timeout, stall_cnt, memwait_cnt, flush_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: mem_wait=%b timeout=%b cnts=%0d/%0d/%0d want all 0",
               mem_wait, mem_timeout, stall_cnt, memwait_cnt, flush_cnt);
    end
    checks++;
    if (ctrl_vec() !== C_IDLE) begin
      errors++;
      $display("FAIL reset_idle_ctrl: got %b want %b", ctrl_vec(), C_IDLE);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++;
      if (ctrl_vec() !== C_HAZARD) begin
        errors++;
        $display("FAIL hazard_ctrl[%0d]: got %b want %b", i, ctrl_vec(), C_HAZARD);
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctrl_vec() !== C_IDLE) begin
      errors++;
      $display("FAIL hazard_release: got %b want %b", ctrl_vec(), C_IDLE);
    end
    checks++;
    if (stall_cnt !== 4'd2) begin
      errors++;
      $display("FAIL hazard_stall_cnt: got %0d want 2", stall_cnt);
    end
  endtask

  task automatic test_branch_over_hazard();
    do_reset();
    drive(1, 1, 0, 0, 0);
    checks++;
    if (ctrl_vec() !== C_FLUSH) begin
      errors++;
      $display("FAIL branch_ctrl: got %b want %b", ctrl_vec(), C_FLUSH);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL branch_cnts: flush=%0d stall=%0d want flush=1 stall=0", flush_cnt, stall_cnt);
    end
    // Memory stall outranks a branch.
    drive(0, 1, 1, 0, 0);
    checks++;
    if (ctrl_vec() !== C_MSTALL) begin
      errors++;
      $display("FAIL mstall_over_branch: got %b want %b", ctrl_vec(), C_MSTALL);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (flush_cnt !== 4'd1 || memwait_cnt !== 4'd1) begin
      errors++;
      $display("FAIL mstall_over_branch_cnts: flush=%0d memwait=%0d want 1/1", flush_cnt, memwait_cnt);
    end
  endtask

  task automatic test_mem_stall();
    logic exp_wait;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      if (c <= 5)      drive(1, 0, 1, 0, 0);
      else if (c == 6) drive(1, 0, 1, 1, 0);
      else             drive(0, 0, 0, 0, 0);
      exp_wait = (c >= 2 && c <= 6);
      checks++;
      if (mem_wait !== exp_wait) begin
        errors++;
        $display("FAIL mem_wait_cycle%0d: got %b want %b", c, mem_wait, exp_wait);
      end
      if (c <= 6) begin
        checks++;
        if (ctrl_vec() !== ((c <= 5) ? C_MSTALL : C_HAZARD)) begin
          errors++;
          $display("FAIL mem_ctrl_cycle%0d: got %b want %b", c, ctrl_vec(),
                   (c <= 5) ? C_MSTALL : C_HAZARD);
        end
      end
      if (c < 7) next_cycle();
    end
    checks++;
    if (memwait_cnt !== 4'd5 || stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL mem_cnts: memwait=%0d stall=%0d want 5/1", memwait_cnt, stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 1, 0, 0);
      next_cycle();
      checks++;
      if (mem_timeout !== (k >= 5)) begin
        errors++;
        $display("FAIL timeout_after_cycle%0d: got %b want %b", k, mem_timeout, (k >= 5));
      end
    end
    drive(0, 0, 1, 1, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    next_cycle();
    checks++;
    if (mem_timeout !== 1'b1 || mem_wait !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: timeout=%b mem_wait=%b want 1/0", mem_timeout, mem_wait);
    end
    checks++;
    if (memwait_cnt !== 4'd10) begin
      errors++;
      $display("FAIL timeout_memwait_cnt: got %0d want 10", memwait_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 0, 0, 0);
      next_cycle();
      if (i >= 15) begin
        checks++;
        if (stall_cnt !== 4'd15) begin
          errors++;
          $display("FAIL sat_stall_cnt_after%0d: got %0d want 15", i, stall_cnt);
        end
      end
    end
    drive(1, 0, 0, 0, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL perf_clr_over_inc: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, 0);
      next_cycle();
    end
    checks++;
    if (mem_wait !== 1'b1 || mem_timeout !== 1'b1 || memwait_cnt !== 4'd6) begin
      errors++;
      $display("FAIL pre_reset_wait: mem_wait=%b timeout=%b memwait=%0d want 1/1/6",
               mem_wait, mem_timeout, memwait_cnt);
    end
    rst = 1'b1;
    drive(1, 0, 1, 0, 0);
    checks++;
    if (ctrl_vec() !== C_RESET) begin
      errors++;
      $display("FAIL mid_wait_reset_ctrl: got %b want %b", ctrl_vec(), C_RESET);
    end
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({mem_wait, mem_timeout, stall_cnt, memwait_cnt, flush_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_wait_reset_state: mem_wait=%b timeout=%b cnts=%0d/%0d/%0d want all 0",
               mem_wait, mem_timeout, stall_cnt, memwait_cnt, flush_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    next_cycle();
    test_reset();
    test_hazard();
    test_branch_over_hazard();
    test_mem_stall();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
